// File: rtl/ddr_pkg.sv
// ddr_pkg
//   Shared constants and types for the DDR read responder slice.
//   DDR_ADDR_WIDTH / DDR_DATA_WIDTH : default address and beat widths
//   LINE_OFFSET                     : byte-address bit where the line index starts (64-byte lines)
//   CNT_WIDTH                       : width of the latency and beat counters (covers 1..16)
//   ddr_state_e                     : responder FSM states
package ddr_pkg;

  localparam int DDR_ADDR_WIDTH = 32;
  localparam int DDR_DATA_WIDTH = 512;
  localparam int LINE_OFFSET    = 6;
  localparam int CNT_WIDTH      = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_BURST    = 2'd2,
    ST_DONE_GAP = 2'd3
  } ddr_state_e;

endpackage

// File: rtl/ddr_line_ram.sv
// ddr_line_ram
//   Line storage for the read responder: one write port, one synchronous
//   read port. Read-first: a read and a write to the same line on the same
//   edge return the old contents. The array has no reset, so contents
//   survive a responder reset.
//   clk      : clock
//   wr_en    : write strobe
//   wr_line  : write line index
//   wr_data  : write data
//   rd_en    : read strobe, rd_data updates on the next edge
//   rd_line  : read line index
//   rd_data  : registered read data
module ddr_line_ram #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_line,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_line,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  // Both assignments are non-blocking, so a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_line] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_line];
    end
  end

endmodule

// File: rtl/ddr_rd_responder.sv
// ddr_rd_responder
//   Answers a read request with BURST_LEN consecutive beats from the line
//   RAM, the first beat appearing RD_LATENCY cycles after the accept cycle
//   (the cycle in which ddr_rd is seen while ready). The line index wraps
//   past the top line. Requests arriving while busy are dropped and flagged.
//   Optional feature macro: ADDR_RANGE_CHECK_EN adds the sticky addr_err
//   output, set when an accepted address has bits above the line index.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | ready for a request
//   WAIT      | latency countdown, last WAIT cycle issues the first read
//   BURST     | one valid beat per cycle, done on the last beat
//   DONE_GAP  | one quiet cycle before returning to IDLE
//
//   Ports
//   clk, rst        : clock, asynchronous active-low reset
//   ddr_rd, readAdd : read request and byte address
//   ddr_rd_ready    : high in IDLE
//   ddr_rd_valid    : beat valid
//   ddr_rd_data     : beat data, zero when not valid
//   ddr_rd_done     : pulse with the last beat
//   wr_en/addr/data : preload write port
//   rd_drop         : sticky, request seen while busy
//   addr_err        : (ADDR_RANGE_CHECK_EN only) sticky out-of-range flag
module ddr_rd_responder
  import ddr_pkg::*;
#(
  parameter int ADDR_WIDTH = DDR_ADDR_WIDTH,
  parameter int DATA_WIDTH = DDR_DATA_WIDTH,
  parameter int DEPTH_LOG2 = 10,
  parameter int BURST_LEN  = 4,
  parameter int RD_LATENCY = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ddr_rd,
  input  logic [ADDR_WIDTH-1:0] readAdd,
  output logic                  ddr_rd_ready,
  output logic                  ddr_rd_valid,
  output logic [DATA_WIDTH-1:0] ddr_rd_data,
  output logic                  ddr_rd_done,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
`ifdef ADDR_RANGE_CHECK_EN
  output logic                  addr_err,
`endif
  output logic                  rd_drop
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LAT_LOAD  = CNT_WIDTH'(RD_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

  ddr_state_e            state, state_nxt;
  logic [CNT_WIDTH-1:0]  lat_cnt, lat_cnt_nxt;
  logic [CNT_WIDTH-1:0]  beat_cnt, beat_cnt_nxt;
  logic [DEPTH_LOG2-1:0] line_idx, line_idx_nxt;
  logic [DEPTH_LOG2-1:0] req_line, wr_line, rd_line;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  unused_addr_bits;

  assign req_line = readAdd[LINE_OFFSET +: DEPTH_LOG2];
  assign wr_line  = wr_addr[LINE_OFFSET +: DEPTH_LOG2];

  // Offset bits and bits above the line index play no part in addressing.
  assign unused_addr_bits = ^{readAdd, wr_addr};

  ddr_line_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_line_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_line (wr_line),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_line (rd_line),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      line_idx <= '0;
      rd_drop  <= 1'b0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_cnt_nxt;
      beat_cnt <= beat_cnt_nxt;
      line_idx <= line_idx_nxt;
      if (ddr_rd && (state != ST_IDLE)) begin
        rd_drop <= 1'b1;
      end
    end
  end

  // The RAM read for beat k is issued on the edge that starts beat k, so the
  // read address always runs one line ahead of the beat on the bus.
  always_comb begin
    state_nxt    = state;
    lat_cnt_nxt  = lat_cnt;
    beat_cnt_nxt = beat_cnt;
    line_idx_nxt = line_idx;
    rd_en        = 1'b0;
    rd_line      = line_idx;
    ddr_rd_ready = 1'b0;
    ddr_rd_valid = 1'b0;
    ddr_rd_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        ddr_rd_ready = 1'b1;
        rd_line      = req_line;
        if (ddr_rd) begin
          line_idx_nxt = req_line;
          beat_cnt_nxt = '0;
          if (RD_LATENCY == 1) begin
            // No WAIT cycles: first read goes out on the accept edge.
            state_nxt   = ST_BURST;
            lat_cnt_nxt = '0;
            rd_en       = 1'b1;
          end else begin
            state_nxt   = ST_WAIT;
            lat_cnt_nxt = LAT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        lat_cnt_nxt = lat_cnt - CNT_ONE;
        if (lat_cnt == CNT_ONE) begin
          state_nxt = ST_BURST;
          rd_en     = 1'b1;
        end
      end
      ST_BURST: begin
        ddr_rd_valid = 1'b1;
        rd_line      = line_idx + DEPTH_LOG2'(beat_cnt) + DEPTH_LOG2'(1);
        if (beat_cnt == LAST_BEAT) begin
          ddr_rd_done  = 1'b1;
          beat_cnt_nxt = '0;
          state_nxt    = ST_DONE_GAP;
        end else begin
          rd_en        = 1'b1;
          beat_cnt_nxt = beat_cnt + CNT_ONE;
        end
      end
      ST_DONE_GAP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // RAM output register is not reset; gating by valid keeps the bus at zero.
  assign ddr_rd_data = ddr_rd_valid ? ram_q : '0;

`ifdef ADDR_RANGE_CHECK_EN
  logic addr_high;

  assign addr_high = (readAdd >> (DEPTH_LOG2 + LINE_OFFSET)) != '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err <= 1'b0;
    end else if (ddr_rd_ready && ddr_rd && addr_high) begin
      addr_err <= 1'b1;
    end
  end
`endif

endmodule
